// File: rtl/ascon_round_counter.sv
// Round counter and round-constant source for the ASCON permutation.
// Rounds are indexed in 12-round numbering so rc_o follows from the count.
module ascon_round_counter #(
  parameter int CPT_W    = 4,
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             en_i,
  input  logic             start_a_i,
  input  logic             start_b_i,
  input  logic             start_n_i,
  input  logic [CPT_W-1:0] rounds_i,
  input  logic             abort_i,
  output logic [CPT_W-1:0] cpt_o,
  output logic [7:0]       rc_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic {IDLE, RUN} state_t;

  // ROUNDS_A may equal 2**CPT_W; it truncates to 0 in CPT_W bits, which
  // still gives the right start index under modular subtraction.
  localparam logic [CPT_W-1:0] RA_W     = CPT_W'(ROUNDS_A);
  localparam logic [CPT_W:0]   RA_EXT   = (CPT_W+1)'(ROUNDS_A);
  localparam logic [CPT_W-1:0] LAST_IDX = CPT_W'(ROUNDS_A - 1);
  localparam logic [CPT_W-1:0] B_START  = CPT_W'(ROUNDS_A - ROUNDS_B);

  state_t           state, state_n;
  logic [CPT_W-1:0] cpt, cpt_n;
  logic             done_n, err_n;
  logic             n_ok;

  assign n_ok = (rounds_i != '0) && ({1'b0, rounds_i} <= RA_EXT);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state  <= IDLE;
      cpt    <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_n;
      cpt    <= cpt_n;
      done_o <= done_n;
      err_o  <= err_n;
    end
  end

  // Commands are prioritised abort > start_a > start_b > start_n > en.
  always_comb begin
    state_n = state;
    cpt_n   = cpt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (abort_i) begin
      state_n = IDLE;
      cpt_n   = '0;
    end else if (start_a_i) begin
      state_n = RUN;
      cpt_n   = '0;
    end else if (start_b_i) begin
      state_n = RUN;
      cpt_n   = B_START;
    end else if (start_n_i) begin
      if (n_ok) begin
        state_n = RUN;
        cpt_n   = RA_W - rounds_i;
      end else begin
        err_n = 1'b1;
      end
    end else if (en_i && state == RUN) begin
      if (cpt == LAST_IDX) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        cpt_n = cpt + CPT_W'(1);
      end
    end
  end

  assign cpt_o  = cpt;
  assign busy_o = (state == RUN);
  assign last_o = busy_o && (cpt == LAST_IDX);
  assign rc_o   = {4'hF - cpt[3:0], cpt[3:0]};

endmodule
